// File: rtl/assignment_trail.sv
// assignment_trail: ordered trail of BCP variable assignments, tagged by decision level.
// Decisions and implications push onto a LIFO. A backtrack request unwinds it one
// entry per cycle, down to and including the most recent decision, and reports
// each removed assignment. Define TRAIL_STATS_EN to add push-count and
// high-water-mark statistics outputs.
module assignment_trail #(
   parameter int FORMULA_MAX_VARIABLE  = 20,
   parameter int VARIABLE_ENCODING_LEN = $clog2(FORMULA_MAX_VARIABLE + 1),
   parameter int DEPTH_LEN             = $clog2(FORMULA_MAX_VARIABLE + 1)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             decision_valid_i,
   input  logic [VARIABLE_ENCODING_LEN:0]   decision_i,
   input  logic                             implication_valid_i,
   input  logic [VARIABLE_ENCODING_LEN:0]   implication_i,
   input  logic                             backtrack_req_i,
   output logic                             unassign_valid_o,
   output logic [VARIABLE_ENCODING_LEN:0]   unassign_o,
   output logic                             unassign_decision_o,
   output logic                             backtrack_done_o,
   output logic                             unsat_o,
   output logic                             busy_o,
   output logic [DEPTH_LEN-1:0]             depth_o,
   output logic [DEPTH_LEN-1:0]             level_o,
   output logic                             overflow_o,
`ifdef TRAIL_STATS_EN
   output logic [31:0]                      stat_push_count_o,
   output logic [DEPTH_LEN-1:0]             stat_max_depth_o,
`endif
   output logic                             protocol_err_o
);

   localparam int LIT_W = VARIABLE_ENCODING_LEN + 1;
   localparam logic [DEPTH_LEN-1:0] DEPTH_MAX = DEPTH_LEN'(FORMULA_MAX_VARIABLE);
   localparam logic [DEPTH_LEN-1:0] DEPTH_ONE = DEPTH_LEN'(1);

   typedef enum logic {IDLE, UNWIND} state_e;

   typedef struct packed {
      logic             is_decision;
      logic [LIT_W-1:0] lit;
   } entry_t;

   entry_t                trail_q [FORMULA_MAX_VARIABLE];
   state_e                state_q;
   logic [DEPTH_LEN-1:0]  depth_q;
   logic [DEPTH_LEN-1:0]  level_q;
   logic                  unassign_valid_q;
   logic [LIT_W-1:0]      unassign_q;
   logic                  unassign_decision_q;
   logic                  backtrack_done_q;
   logic                  unsat_q;
   logic                  overflow_q;
   logic                  protocol_err_q;

   logic                  any_push;
   logic                  full;
   logic                  push_we;
   entry_t                push_entry;
   entry_t                top_entry;
   logic [DEPTH_LEN-1:0]  top_idx;

   // Decode the incoming push and the current top-of-trail entry.
   always_comb begin
      any_push               = decision_valid_i | implication_valid_i;
      full                   = (depth_q == DEPTH_MAX);
      push_entry.is_decision = ~implication_valid_i;
      push_entry.lit         = implication_valid_i ? implication_i : decision_i;
      push_we                = (state_q == IDLE) && !backtrack_req_i && any_push && !full;
      top_idx                = depth_q - DEPTH_ONE;
      top_entry              = trail_q[top_idx];
   end

   // Trail storage write port.
   // NOTE: the trail array has no reset; depth_q alone decides which entries are live.
   always_ff @(posedge clk_i) begin
      if (push_we) trail_q[depth_q] <= push_entry;
   end

   // Control FSM: push in IDLE, pop one entry per cycle in UNWIND; all outputs registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q             <= IDLE;
         depth_q             <= '0;
         level_q             <= '0;
         unassign_valid_q    <= 1'b0;
         unassign_q          <= '0;
         unassign_decision_q <= 1'b0;
         backtrack_done_q    <= 1'b0;
         unsat_q             <= 1'b0;
         overflow_q          <= 1'b0;
         protocol_err_q      <= 1'b0;
      end else begin
         // NOTE: strobes default low here so each one lasts exactly one cycle after its event.
         unassign_valid_q    <= 1'b0;
         unassign_decision_q <= 1'b0;
         backtrack_done_q    <= 1'b0;
         unsat_q             <= 1'b0;
         case (state_q)
            IDLE: begin
               if (backtrack_req_i) begin
                  if (any_push) protocol_err_q <= 1'b1;
                  if (depth_q == '0) begin
                     backtrack_done_q <= 1'b1;
                     unsat_q          <= 1'b1;
                  end else begin
                     state_q <= UNWIND;
                  end
               end else if (any_push) begin
                  if (decision_valid_i && implication_valid_i) protocol_err_q <= 1'b1;
                  if (full) begin
                     overflow_q <= 1'b1;
                  end else begin
                     depth_q <= depth_q + DEPTH_ONE;
                     if (!implication_valid_i) level_q <= level_q + DEPTH_ONE;
                  end
               end
            end
            UNWIND: begin
               if (any_push || backtrack_req_i) protocol_err_q <= 1'b1;
               unassign_valid_q    <= 1'b1;
               unassign_q          <= top_entry.lit;
               unassign_decision_q <= top_entry.is_decision;
               depth_q             <= depth_q - DEPTH_ONE;
               if (top_entry.is_decision) begin
                  level_q          <= level_q - DEPTH_ONE;
                  backtrack_done_q <= 1'b1;
                  state_q          <= IDLE;
               end else if (depth_q == DEPTH_ONE) begin
                  backtrack_done_q <= 1'b1;
                  unsat_q          <= 1'b1;
                  state_q          <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef TRAIL_STATS_EN
   logic [31:0]          stat_push_count_q;
   logic [DEPTH_LEN-1:0] stat_max_depth_q;

   // Saturating accepted-push counter and depth high-water mark.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_push_count_q <= '0;
         stat_max_depth_q  <= '0;
      end else if (push_we) begin
         if (stat_push_count_q != '1) stat_push_count_q <= stat_push_count_q + 32'd1;
         if (depth_q + DEPTH_ONE > stat_max_depth_q) stat_max_depth_q <= depth_q + DEPTH_ONE;
      end
   end

   assign stat_push_count_o = stat_push_count_q;
   assign stat_max_depth_o  = stat_max_depth_q;
`endif

   assign unassign_valid_o    = unassign_valid_q;
   assign unassign_o          = unassign_q;
   assign unassign_decision_o = unassign_decision_q;
   assign backtrack_done_o    = backtrack_done_q;
   assign unsat_o             = unsat_q;
   assign busy_o              = (state_q == UNWIND);
   assign depth_o             = depth_q;
   assign level_o             = level_q;
   assign overflow_o          = overflow_q;
   assign protocol_err_o      = protocol_err_q;

endmodule
